// File: rtl/partial_stub_pkg.sv
// ============================================================================
// Module   : partial_stub_pkg
// Brief    : Shared types and helpers for the partial-circuit stub driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package partial_stub_pkg;

    localparam int N_STUBS_MAX = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } stub_state_e;

    // Bits needed to represent values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/partial_stub_shift.sv
// ============================================================================
// Module   : partial_stub_shift
// Brief    : Right-shift register with serial-in at MSB, enable and parallel load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module partial_stub_shift #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sin,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shifted = i_sin;
        end else begin : g_wn
            assign w_shifted = {i_sin, shift_q[WIDTH-1:1]};
        end
    endgenerate

    // Parallel load takes priority over a shift in the same cycle.
    always_comb begin
        shift_d = shift_q;
        if (i_load) begin
            shift_d = i_load_val;
        end else if (i_en) begin
            shift_d = w_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= RESET_VAL;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign o_q = shift_q;

endmodule

`default_nettype wire

// File: rtl/partial_stub_driver.sv
// ============================================================================
// Module   : partial_stub_driver
// Brief    : Serially loads a stub vector and commits it atomically to O_stub.
//            Optional readback via macro PARTIAL_STUB_DRIVER_READBACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module partial_stub_driver
    import partial_stub_pkg::*;
#(
    parameter int                 N_STUBS   = 8,
    parameter logic [N_STUBS-1:0] RESET_VAL = '0
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               I_valid,
    input  logic               I_data,
    output logic               I_ready,
    input  logic               I_abort,
    output logic [N_STUBS-1:0] O_stub,
    output logic               O_commit,
`ifdef PARTIAL_STUB_DRIVER_READBACK_EN
    output logic               O_busy,
    output logic               O_scan
`else
    output logic               O_busy
`endif
);

    localparam int               CNT_W      = clog2(N_STUBS + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N_STUBS - 1);

    stub_state_e        state_q;
    stub_state_e        state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [N_STUBS-1:0] stub_q;
    logic [N_STUBS-1:0] stub_d;
    logic               commit_q;
    logic               commit_d;

    logic               w_xfer;
    logic               w_abort;
    logic               w_accept;
    logic [N_STUBS-1:0] w_shadow;

    // An abort in SHIFT swallows the coincident beat.
    assign w_xfer   = I_valid && I_ready;
    assign w_abort  = (state_q == SHIFT) && I_abort;
    assign w_accept = w_xfer && !w_abort;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            count_q  <= '0;
            stub_q   <= RESET_VAL;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            stub_q   <= stub_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = (N_STUBS == 1) ? COMMIT : SHIFT;
                end
            end
            SHIFT: begin
                if (w_abort) begin
                    state_d = IDLE;
                end else if (w_accept && (count_q == C_CNT_LAST)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        stub_d   = stub_q;
        commit_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    count_d = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (w_abort) begin
                    count_d = '0;
                end else if (w_accept) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                count_d  = '0;
                stub_d   = w_shadow;
                commit_d = 1'b1;
            end
            default: count_d = '0;
        endcase
    end

    always_comb begin
        I_ready  = RESETN && (state_q != COMMIT);
        O_busy   = (state_q != IDLE);
        O_stub   = stub_q;
        O_commit = commit_q;
    end

    partial_stub_shift #(
        .WIDTH     (N_STUBS),
        .RESET_VAL (RESET_VAL)
    ) u_shadow (
        .clk        (CLK),
        .rst_n      (RESETN),
        .i_en       (w_accept),
        .i_sin      (I_data),
        .i_load     (1'b0),
        .i_load_val (RESET_VAL),
        .o_q        (w_shadow)
    );

`ifdef PARTIAL_STUB_DRIVER_READBACK_EN
    logic [N_STUBS-1:0] w_scan;

    // Captures the vector being committed so the next frame can read it back.
    partial_stub_shift #(
        .WIDTH     (N_STUBS),
        .RESET_VAL (RESET_VAL)
    ) u_scan (
        .clk        (CLK),
        .rst_n      (RESETN),
        .i_en       (w_accept),
        .i_sin      (1'b0),
        .i_load     (state_q == COMMIT),
        .i_load_val (w_shadow),
        .o_q        (w_scan)
    );

    assign O_scan = w_accept & w_scan[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_partial_stub_driver.sv
// ============================================================================
// Module   : tb_partial_stub_driver
// Brief    : Scoreboard bench for partial_stub_driver (N_STUBS = 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_partial_stub_driver;

    logic       CLK     = 1'b0;
    logic       RESETN  = 1'b0;
    logic       I_valid = 1'b0;
    logic       I_data  = 1'b0;
    logic       I_abort = 1'b0;
    logic       I_ready;
    logic [7:0] O_stub;
    logic       O_commit;
    logic       O_busy;
`ifdef PARTIAL_STUB_DRIVER_READBACK_EN
    logic       O_scan;
`endif

    partial_stub_driver #(
        .N_STUBS   (8),
        .RESET_VAL (8'h00)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .I_valid  (I_valid),
        .I_data   (I_data),
        .I_ready  (I_ready),
        .I_abort  (I_abort),
        .O_stub   (O_stub),
        .O_commit (O_commit),
`ifdef PARTIAL_STUB_DRIVER_READBACK_EN
        .O_busy   (O_busy),
        .O_scan   (O_scan)
`else
        .O_busy   (O_busy)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         last_commit_cyc = 0;
    logic       scan_seen = 1'b0;
    logic [7:0] scan_bits = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every commit pulse must match the oldest outstanding frame.
    always @(negedge CLK) begin
        if (O_commit === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("spurious_commit", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("stub_value", {24'd0, O_stub}, {24'd0, e.val});
                check("commit_latency", cyc, e.cyc);
            end
            last_commit_cyc = cyc;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic b);
        int guard;
        guard   = 0;
        I_valid = 1'b1;
        I_data  = b;
        #1;
        while (I_ready !== 1'b1 && guard < 8) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        if (guard == 8) check("ready_timeout", 32'd0, 32'd1);
`ifdef PARTIAL_STUB_DRIVER_READBACK_EN
        scan_seen = O_scan;
`endif
        @(posedge CLK);
        @(negedge CLK);
        I_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input int gap, input bit push);
        for (int i = 0; i < 8; i++) begin
            send_beat(v[i]);
            scan_bits[i] = scan_seen;
            if (i < 7) repeat (gap) @(negedge CLK);
        end
        if (push) sb.push_back('{val: v, cyc: cyc + 1});
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge CLK);
            g++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge CLK);
        check("rst_stub", {24'd0, O_stub}, 32'h00);
        check("rst_commit", {31'd0, O_commit}, 32'd0);
        check("rst_busy", {31'd0, O_busy}, 32'd0);
        check("rst_ready", {31'd0, I_ready}, 32'd0);
        RESETN = 1'b1;
        @(negedge CLK);
        check("idle_ready", {31'd0, I_ready}, 32'd1);

        // Basic frame: beats 1,0,1,1,0,0,1,0
        send_frame(8'b0100_1101, 0, 1'b1);
        check("commit_ready_low", {31'd0, I_ready}, 32'd0);
        check("commit_busy", {31'd0, O_busy}, 32'd1);
        @(negedge CLK);
        check("ready_back", {31'd0, I_ready}, 32'd1);
        wait_drain();

        // Back-to-back frames
        c0 = cyc;
        send_frame(8'hFF, 0, 1'b1);
        send_frame(8'h00, 0, 1'b1);
        wait_drain();
        check("b2b_span", last_commit_cyc - (c0 + 1), 32'd17);
        check("b2b_final", {24'd0, O_stub}, 32'h00);

        // Abort coinciding with the 6th beat
        send_frame(8'hA5, 0, 1'b1);
        wait_drain();
        for (int i = 0; i < 5; i++) send_beat(1'b1);
        check("pre_abort_busy", {31'd0, O_busy}, 32'd1);
        I_valid = 1'b1;
        I_data  = 1'b1;
        I_abort = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        I_valid = 1'b0;
        I_abort = 1'b0;
        check("abort_busy", {31'd0, O_busy}, 32'd0);
        repeat (3) @(negedge CLK);
        check("abort_hold", {24'd0, O_stub}, 32'hA5);
        send_frame(8'hA5 ^ 8'hFF, 0, 1'b1);
        wait_drain();

        // Reset after 4 beats
        for (int i = 0; i < 4; i++) send_beat(1'b1);
        RESETN = 1'b0;
        #1;
        check("rst_ready_low", {31'd0, I_ready}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_stub", {24'd0, O_stub}, 32'h00);
        check("midrst_busy", {31'd0, O_busy}, 32'd0);
        RESETN = 1'b1;
        @(negedge CLK);
        send_frame(8'h5A, 0, 1'b1);
        wait_drain();

        // Reset during the COMMIT cycle
        send_frame(8'hC3, 0, 1'b0);
        RESETN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("cmtrst_stub", {24'd0, O_stub}, 32'h00);
        check("cmtrst_commit", {31'd0, O_commit}, 32'd0);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);

        // Gapped beats, one every third cycle
        send_frame(8'h3C, 2, 1'b1);
        wait_drain();
        check("gap_final", {24'd0, O_stub}, 32'h3C);

`ifdef PARTIAL_STUB_DRIVER_READBACK_EN
        send_frame(8'h96, 0, 1'b1);
        check("scan_prev", {24'd0, scan_bits}, 32'h3C);
        wait_drain();
        send_frame(8'h00, 0, 1'b1);
        check("scan_bits", {24'd0, scan_bits}, 32'h96);
        wait_drain();
`endif

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/partial_stub_driver.md
Name: partial_stub_driver

Overview:
- Supplies values for the stub (formerly undriven) nets of an extracted partial circuit; the inverse direction of partial extraction, driving signals into the cut boundary instead of exposing them.
- Receives a serial frame of N_STUBS bits over a valid/ready stream and stages it in a shadow shift register.
- Commits the whole frame atomically to the stub outputs, so the partial circuit never sees a half-loaded vector.
- Sits between the test/debug harness and the stub inputs of a `_Partial` module.

Parameters:
- N_STUBS, 8: number of stub nets driven; legal range 1..256.
- RESET_VAL, 0: value (N_STUBS bits) loaded into O_stub and the shadow register on reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETN  input  1  synchronous, active-low reset.
- I_valid  input  1  serial beat valid.
- I_data  input  1  serial beat payload; bit 0 of the frame arrives first.
- I_ready  output  1  block accepts a beat this cycle.
- I_abort  input  1  discard the frame in progress.
- O_stub  output  N_STUBS  committed stub values.
- O_commit  output  1  one-cycle pulse when O_stub updates.
- O_busy  output  1  a frame is partially received.
- O_scan  output  1  readback serial output; present only with the optional feature.

Behaviour:
- Beat handshake: a beat transfers when I_valid && I_ready.
- I_ready = 1 in IDLE and SHIFT, 0 in COMMIT.
- Shadow register: on each transfer it shifts right, and I_data enters at MSB (bit N_STUBS-1).
- After N_STUBS beats, shadow bit k holds frame beat k.
- Beat counter: width clog2(N_STUBS+1); counts accepted beats in the current frame.
- FSM states and transitions:
  - IDLE: counter = 0. A transfer moves to SHIFT with count = 1. If N_STUBS = 1, it moves directly to COMMIT.
  - SHIFT: each transfer increments the count. The transfer that brings count to N_STUBS moves to COMMIT. No transfer holds state.
  - COMMIT: one cycle. O_stub <= shadow, O_commit = 1 (registered pulse visible the following cycle), counter cleared, return to IDLE.
- Latency: O_stub changes 2 cycles after the final beat's accepting edge (edge 1 enters COMMIT, edge 2 loads O_stub). O_commit is high in the same cycle O_stub first shows the new value.
- Back-to-back frames: I_ready drops for exactly one cycle between frames; sustained throughput is N_STUBS beats per N_STUBS+1 cycles.
- O_busy = 1 in SHIFT and COMMIT, else 0.
- Abort:
  - I_abort in SHIFT returns to IDLE next cycle, clears the counter, leaves O_stub unchanged, and ignores the coincident beat. Abort wins over a simultaneous valid.
  - I_abort in IDLE or COMMIT is ignored; a commit already started completes.
- O_stub holds its value indefinitely between commits. The shadow register keeps partial contents after an abort, but they are never committed.
- Reset (RESETN = 0 at an edge), from any state including mid-frame or in COMMIT:
  - state = IDLE, counter = 0, shadow = RESET_VAL, O_stub = RESET_VAL, O_commit = 0, O_busy = 0, I_ready = 0 while RESETN is low.
  - No commit pulse results from reset.
- No X propagation: O_stub is always driven, which guarantees no net in the partial circuit is left undriven.

Optional Feature:
- Macro: PARTIAL_STUB_DRIVER_READBACK_EN.
- Defined:
  - O_scan port exists, and O_stub is copied to a scan-out register at each COMMIT.
  - On every accepted beat, O_scan presents scan-out bit 0, then the scan-out register shifts right. The harness thus reads the previously committed vector (LSB first) while loading the next.
  - O_scan = 0 in IDLE before the first beat of a frame; the scan-out register resets to RESET_VAL.
- Undefined: the O_scan port and the scan-out register are absent; all other behaviour is identical.

Decomposition:
- Shared package partial_stub_pkg holds:
  - the state enum {IDLE, SHIFT, COMMIT} (2-bit encoding);
  - the counter-width function clog2;
  - the constant N_STUBS_MAX = 256.
- One natural sub-module: partial_stub_shift, an N_STUBS-wide shift register with enable, serial-in and parallel load/reset. It is instantiated for the shadow register and, under the macro, for the scan-out register.

Test Plan:
- Reset, then a frame with N_STUBS = 8 and beats 1,0,1,1,0,0,1,0 sent on consecutive cycles -> O_stub = 8'b01001101 exactly 2 cycles after the last beat; O_commit pulses once; I_ready = 0 for one cycle.
- Two back-to-back frames 0xFF then 0x00 with I_valid held high -> O_stub goes 0xFF then 0x00; 18 cycles total from first beat to second commit; no beat lost.
- Send 5 beats, assert I_abort together with the 6th beat -> no commit; O_stub unchanged; O_busy = 0 next cycle; the following full frame 0xA5 commits 0xA5.
- Drop RESETN mid-frame after 4 beats, and again in the COMMIT cycle -> O_stub = RESET_VAL, no O_commit pulse; the next full frame commits correctly.
- Gapped I_valid (beats on every third cycle), frame 0x3C -> O_stub = 0x3C; counter holds across gaps.
- With PARTIAL_STUB_DRIVER_READBACK_EN: commit 0x96, then load 0x00 -> O_scan emits 0,1,1,0,1,0,0,1 on the 8 accepted beats.
